wram_arbiter: RTL and testbench

Round-robin arbiter that shares the single read/write port of the working-RAM bank array (NUM_BANKS × 512 × 32 OpenRAM macros) between the two leorv32 cores and the Wishbone bridge. It sits inside the SoC between the requesters and the `wram` macro wrapper. It decodes the bank from the word address and sequences each access as a three-state transaction. It returns read data to the winning requester with a one-cycle `ready` pulse.

---
 rtl/leosoc_pkg.sv | 18 +
 rtl/rr_select.sv | 24 ++
 rtl/wram_arbiter.sv | 153 +++++++++++++++
 tb/tb_wram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leosoc_pkg.sv
// Shared SoC definitions: arbiter state encoding, requester indices and
// working-RAM geometry.
package leosoc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int REQ_CORE0 = 0;
  localparam int REQ_CORE1 = 1;
  localparam int REQ_WB    = 2;

  localparam int WRAM_NUM_BANKS = 4;
  localparam int WRAM_BANK_AW   = 9;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set valid bit at or after ptr,
// wrapping from N-1 back to 0.
module rr_select #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  always_comb begin
    winner    = '0;
    any_valid = |valid;
    // Scan farthest-first so the candidate closest to ptr is the last written.
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        winner = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wram_arbiter.sv
// Round-robin arbiter sharing the working-RAM bank port between the cores and
// the Wishbone bridge; each access runs IDLE -> ACCESS -> RESP.
module wram_arbiter
  import leosoc_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int NUM_BANKS = WRAM_NUM_BANKS,
  parameter int BANK_AW   = WRAM_BANK_AW
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [4*NREQ-1:0]           req_wmask,
  input  logic [(BANK_AW+2)*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0]          req_wdata,
  output logic [NREQ-1:0]             req_ready,
  output logic [31:0]                 req_rdata,
  output logic [NUM_BANKS-1:0]        sram_csb,
  output logic                        sram_web,
  output logic [3:0]                  sram_wmask,
  output logic [BANK_AW-1:0]          sram_addr,
  output logic [31:0]                 sram_din,
  input  logic [32*NUM_BANKS-1:0]     sram_dout
);

  localparam int AW = BANK_AW + 2;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [3:0]    wmask_arr [NREQ];
  logic [31:0]   wdata_arr [NREQ];
  logic [31:0]   dout_arr  [NUM_BANKS];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wmask_arr[gi] = req_wmask[gi*4 +: 4];
      assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
    end
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign dout_arr[gi] = sram_dout[gi*32 +: 32];
    end
  endgenerate

  arb_state_e           state_reg, state_next;
  logic [IW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]        winner_reg, winner_next;
  logic [1:0]           bank_reg, bank_next;
  logic                 we_reg, we_next;
  logic [NUM_BANKS-1:0] csb_reg, csb_next;
  logic                 web_reg, web_next;
  logic [3:0]           wmask_reg, wmask_next;
  logic [BANK_AW-1:0]   addr_reg, addr_next;
  logic [31:0]          din_reg, din_next;

  logic [IW-1:0] pick;
  logic          any_valid;
  logic [AW-1:0] pick_addr;

  rr_select #(.N(NREQ), .IW(IW)) u_rr_select (
    .valid     (req_valid),
    .ptr       (rr_ptr_reg),
    .winner    (pick),
    .any_valid (any_valid)
  );

  assign pick_addr = addr_arr[pick];

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    winner_next = winner_reg;
    bank_next   = bank_reg;
    we_next     = we_reg;
    csb_next    = csb_reg;
    web_next    = web_reg;
    wmask_next  = wmask_reg;
    addr_next   = addr_reg;
    din_next    = din_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next  = ACCESS;
          winner_next = pick;
          bank_next   = pick_addr[AW-1:BANK_AW];
          we_next     = req_we[pick];
          wmask_next  = wmask_arr[pick];
          addr_next   = pick_addr[BANK_AW-1:0];
          din_next    = wdata_arr[pick];
          csb_next    = '1;
          csb_next[pick_addr[AW-1:BANK_AW]] = 1'b0;
          web_next    = ~req_we[pick];
        end
      end
      ACCESS: begin
        state_next = RESP;
        csb_next   = '1;
        web_next   = 1'b1;
      end
      RESP: begin
        state_next  = IDLE;
        rr_ptr_next = (winner_reg == IW'(NREQ - 1)) ? '0 : winner_reg + IW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      winner_reg <= '0;
      bank_reg   <= '0;
      we_reg     <= 1'b0;
      csb_reg    <= '1;
      web_reg    <= 1'b1;
      wmask_reg  <= '0;
      addr_reg   <= '0;
      din_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      winner_reg <= winner_next;
      bank_reg   <= bank_next;
      we_reg     <= we_next;
      csb_reg    <= csb_next;
      web_reg    <= web_next;
      wmask_reg  <= wmask_next;
      addr_reg   <= addr_next;
      din_reg    <= din_next;
    end
  end

  // Macro read data only becomes valid in RESP, so rdata is steered live.
  always_comb begin
    req_ready = '0;
    req_rdata = '0;
    if (state_reg == RESP) begin
      req_ready[winner_reg] = 1'b1;
      if (!we_reg) begin
        req_rdata = dout_arr[bank_reg];
      end
    end
  end

  assign sram_csb   = csb_reg;
  assign sram_web   = web_reg;
  assign sram_wmask = wmask_reg;
  assign sram_addr  = addr_reg;
  assign sram_din   = din_reg;

endmodule

// File: tb/tb_wram_arbiter.sv
// Bench for wram_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level reference model.
module tb_wram_arbiter;
  import leosoc_pkg::*;

  localparam int NREQ = 3;
  localparam int NB   = 4;
  localparam int BAW  = 9;
  localparam int AW   = BAW + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [4*NREQ-1:0] req_wmask;
  logic [AW*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       req_rdata;
  logic [NB-1:0]     sram_csb;
  logic              sram_web;
  logic [3:0]        sram_wmask;
  logic [BAW-1:0]    sram_addr;
  logic [31:0]       sram_din;
  logic [32*NB-1:0]  sram_dout;

  logic [AW-1:0] f_addr  [NREQ];
  logic [3:0]    f_wmask [NREQ];
  logic [31:0]   f_wdata [NREQ];

  always #5 clk = ~clk;

  wram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural SRAM banks: inputs captured at the edge, dout valid next cycle.
  logic [31:0] sram_mem [NB][512];
  logic [31:0] dout_q   [NB];
  logic        init_done = 1'b0;

  function automatic logic [31:0] pat(input int b, input int r);
    return 32'hA000_0000 | (32'(b) << 16) | 32'(r);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int b = 0; b < NB; b++) begin
        dout_q[b] <= '0;
        for (int r = 0; r < 512; r++) sram_mem[b][r] <= pat(b, r);
      end
      init_done <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (!sram_csb[b]) begin
          if (!sram_web) begin
            for (int k = 0; k < 4; k++)
              if (sram_wmask[k]) sram_mem[b][sram_addr][8*k +: 8] <= sram_din[8*k +: 8];
          end else begin
            dout_q[b] <= sram_mem[b][sram_addr];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_addr[gi*AW +: AW]  = f_addr[gi];
      assign req_wmask[gi*4 +: 4]   = f_wmask[gi];
      assign req_wdata[gi*32 +: 32] = f_wdata[gi];
    end
    for (genvar gi = 0; gi < NB; gi++) begin : g_dout
      assign sram_dout[gi*32 +: 32] = dout_q[gi];
    end
  endgenerate

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic        we;
    logic [3:0]  mask;
    logic [10:0] addr;
    logic [31:0] wdata;
    int          bank;
    int          row;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic set_req(input int i, input logic we, input logic [3:0] m,
                         input logic [10:0] a, input logic [31:0] d);
    req_we[i]  = we;
    f_wmask[i] = m;
    f_addr[i]  = a;
    f_wdata[i] = d;
  endtask

  // Single requester, arbiter idle: csb low one cycle later, ready two later.
  task automatic run_vec(input vec_t v);
    logic [3:0] ecsb;
    logic [2:0] erdy;
    ecsb = 4'hF;
    ecsb[v.bank] = 1'b0;
    erdy = '0;
    erdy[v.idx] = 1'b1;
    @(negedge clk);
    set_req(v.idx, v.we, v.mask, v.addr, v.wdata);
    req_valid[v.idx] = 1'b1;
    @(negedge clk);
    check("vec_csb", 32'(sram_csb), 32'(ecsb));
    check("vec_row", 32'(sram_addr), 32'(v.row));
    check("vec_web", 32'(sram_web), 32'(!v.we));
    check("vec_early_ready", 32'(req_ready), 32'h0);
    if (v.we) begin
      check("vec_wmask", 32'(sram_wmask), 32'(v.mask));
      check("vec_din", sram_din, v.wdata);
    end
    @(negedge clk);
    check("vec_ready", 32'(req_ready), 32'(erdy));
    check("vec_rdata", req_rdata, v.rdata);
    check("vec_csb_idle", 32'(sram_csb), 32'hF);
    req_valid[v.idx] = 1'b0;
    $display("vec req=%0d we=%0d addr=%h wdata=%h rdata=%h", v.idx, v.we, v.addr, v.wdata, req_rdata);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model state for the randomized run
  logic [31:0] ref_mem [NB*512];
  bit          pend [NREQ];

  initial begin
    logic [2:0]  erdy;
    logic [3:0]  ecsb;
    logic [31:0] exp_rd [NREQ];
    int idle_at, acc_cyc, done_cyc, done_idx, ptr, w, b, r;
    logic [3:0]  m_csb;
    logic [8:0]  m_row;
    logic        m_web;
    logic [31:0] m_rd;

    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'h0, 11'h0, 32'h0);

    vecs[0]  = '{0, 1'b1, 4'hF, 11'h205, 32'hDEADBEEF, 1, 9'h005, 32'h0};
    vecs[1]  = '{0, 1'b0, 4'hF, 11'h205, 32'h0,        1, 9'h005, 32'hDEADBEEF};
    vecs[2]  = '{2, 1'b1, 4'hF, 11'h310, 32'h11223344, 1, 9'h110, 32'h0};
    vecs[3]  = '{1, 1'b1, 4'h4, 11'h310, 32'h00AB0000, 1, 9'h110, 32'h0};
    vecs[4]  = '{2, 1'b0, 4'hF, 11'h310, 32'h0,        1, 9'h110, 32'h11AB3344};
    vecs[5]  = '{1, 1'b1, 4'h0, 11'h310, 32'hFFFFFFFF, 1, 9'h110, 32'h0};
    vecs[6]  = '{0, 1'b0, 4'hF, 11'h310, 32'h0,        1, 9'h110, 32'h11AB3344};
    vecs[7]  = '{1, 1'b0, 4'hF, 11'h000, 32'h0,        0, 9'h000, 32'hA0000000};
    vecs[8]  = '{2, 1'b0, 4'hF, 11'h1FF, 32'h0,        0, 9'h1FF, 32'hA00001FF};
    vecs[9]  = '{0, 1'b0, 4'hF, 11'h200, 32'h0,        1, 9'h000, 32'hA0010000};
    vecs[10] = '{1, 1'b0, 4'hF, 11'h7FF, 32'h0,        3, 9'h1FF, 32'hA00301FF};
    vecs[11] = '{2, 1'b1, 4'hF, 11'h7FF, 32'hCAFEF00D, 3, 9'h1FF, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_csb", 32'(sram_csb), 32'hF);
    check("rst_web", 32'(sram_web), 32'h1);
    check("rst_wmask", 32'(sram_wmask), 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_din", sram_din, 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rdata", req_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during ACCESS aborts the transaction
    @(negedge clk);
    set_req(0, 1'b0, 4'hF, 11'h205, 32'h0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("abort_csb_access", 32'(sram_csb), 32'hD);
    reset_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'h0);
    check("abort_csb", 32'(sram_csb), 32'hF);
    check("abort_web", 32'(sram_web), 32'h1);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(req_ready), 32'h0);
    run_vec(vecs[1]);
    $display("abort sequence done");

    // All three requesters valid continuously from reset
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_req(0, 1'b0, 4'hF, 11'h001, 32'h0);
    set_req(1, 1'b0, 4'hF, 11'h402, 32'h0);
    set_req(2, 1'b0, 4'hF, 11'h603, 32'h0);
    exp_rd[0] = pat(0, 1);
    exp_rd[1] = pat(2, 2);
    exp_rd[2] = pat(3, 3);
    req_valid = 3'b111;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      erdy = '0;
      if (c % 3 == 2) erdy[(c / 3) % 3] = 1'b1;
      check("rr_ready", 32'(req_ready), 32'(erdy));
      if (c % 3 == 2) begin
        check("rr_rdata", req_rdata, exp_rd[(c / 3) % 3]);
        $display("rr cycle=%0d ready=%b rdata=%h", c, req_ready, req_rdata);
      end
    end
    req_valid = '0;

    // Requester 1 drops valid (and garbles its address) during ACCESS
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_req(1, 1'b0, 4'hF, 11'h402, 32'h0);
    set_req(2, 1'b0, 4'hF, 11'h603, 32'h0);
    req_valid = 3'b110;
    @(negedge clk);
    check("drop_csb1", 32'(sram_csb), 32'hB);
    req_valid[1] = 1'b0;
    f_addr[1] = 11'h000;
    @(negedge clk);
    check("drop_ready1", 32'(req_ready), 32'h2);
    check("drop_rdata1", req_rdata, pat(2, 2));
    @(negedge clk);
    check("drop_gap", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("drop_csb2", 32'(sram_csb), 32'h7);
    @(negedge clk);
    check("drop_ready2", 32'(req_ready), 32'h4);
    check("drop_rdata2", req_rdata, pat(3, 3));
    req_valid = '0;
    repeat (2) begin
      @(negedge clk);
      check("drop_no_repeat", 32'(req_ready), 32'h0);
    end
    $display("drop sequence done");

    // Randomized run against the transaction-level model
    pulse_reset();
    for (int i = 0; i < NB * 512; i++) ref_mem[i] = sram_mem[i / 512][i % 512];
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    idle_at = 0; acc_cyc = -1; done_cyc = -1; done_idx = 0; ptr = 0;
    m_csb = 4'hF; m_row = '0; m_web = 1'b1; m_rd = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) @(negedge clk);
      if (c == acc_cyc) begin
        check("rnd_csb", 32'(sram_csb), 32'(m_csb));
        check("rnd_row", 32'(sram_addr), 32'(m_row));
        check("rnd_web", 32'(sram_web), 32'(m_web));
      end
      erdy = '0;
      if (c == done_cyc) erdy[done_idx] = 1'b1;
      check("rnd_ready", 32'(req_ready), 32'(erdy));
      if (c == done_cyc) begin
        check("rnd_rdata", req_rdata, m_rd);
        $display("rnd cycle=%0d req=%0d we=%0d addr=%h rdata=%h", c, done_idx,
                 req_we[done_idx], f_addr[done_idx], req_rdata);
        pend[done_idx] = 1'b0;
        req_valid[done_idx] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 3);
          if (r == 3) r = 511;
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom), {2'($urandom), 9'(r)}, $urandom);
          pend[i] = 1'b1;
          req_valid[i] = 1'b1;
        end
      end
      if (c >= idle_at) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && pend[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        if (w >= 0) begin
          b = int'(f_addr[w][10:9]);
          r = int'(f_addr[w][8:0]);
          ecsb = 4'hF;
          ecsb[b] = 1'b0;
          m_csb = ecsb;
          m_row = f_addr[w][8:0];
          m_web = ~req_we[w];
          if (req_we[w]) begin
            for (int k = 0; k < 4; k++)
              if (f_wmask[w][k]) ref_mem[b*512 + r][8*k +: 8] = f_wdata[w][8*k +: 8];
            m_rd = '0;
          end else begin
            m_rd = ref_mem[b*512 + r];
          end
          acc_cyc  = c + 1;
          done_cyc = c + 2;
          done_idx = w;
          idle_at  = c + 3;
          ptr      = (w + 1) % NREQ;
        end
      end
    end
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
